// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg
//   Shared definitions for the odd-parity serial link (receiver now,
//   transmitter later): receiver state encoding, line-level constants and
//   the parity-sense definition.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Odd parity: the parity bit is the XNOR-reduction of the data bits.
  // Given the XOR-reduction accumulated so far, return the parity bit
  // that makes the total count of ones odd.
  function automatic logic odd_parity_bit(input logic xor_acc);
    return ~xor_acc;
  endfunction

endpackage

// File: rtl/serial_parity_rx.sv
// serial_parity_rx
//   Receive end of the odd-parity serial link. Samples rx_bit on bit_en
//   strobes, reassembles a DATA_W-bit word (LSB first), checks parity and
//   the stop bit, and presents the word with a one-cycle valid pulse.
//
//   Optional feature: define SERIAL_PARITY_RX_ERRCNT_EN to add err_cnt, a
//   saturating count of frames with a parity and/or framing error.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bit_en     sample strobe for rx_bit
//   rx_bit     serial line (idle high)
//   data_out   last received word
//   data_valid one-cycle pulse on the stop-bit edge
//   parity_err parity result of last frame (held)
//   frame_err  stop bit of last frame was 0 (held)
//   err_cnt    [SERIAL_PARITY_RX_ERRCNT_EN only] saturating error-frame count
//   busy       frame reception in progress
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              xor_acc;
  logic              perr_pend;
  logic              last_bit;

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      unique case (state)
        IDLE:    if (rx_bit == START_BIT) state_nxt = DATA;
        DATA:    if (last_bit) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Parity verdict is held in perr_pend until the stop bit, so that all
  // three result outputs change together with the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      xor_acc    <= 1'b0;
      perr_pend  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        unique case (state)
          IDLE: begin
            if (rx_bit == START_BIT) begin
              cnt     <= '0;
              xor_acc <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {rx_bit, shreg[DATA_W-1:1]};
            xor_acc <= xor_acc ^ rx_bit;
            cnt     <= cnt + CNT_W'(1);
          end
          PARITY: begin
            perr_pend <= (rx_bit != odd_parity_bit(xor_acc));
          end
          STOP: begin
            data_out   <= shreg;
            parity_err <= perr_pend;
            frame_err  <= (rx_bit != STOP_BIT);
            data_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic frame_bad;
  assign frame_bad = perr_pend | (rx_bit != STOP_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bit_en && state == STOP && frame_bad && err_cnt != '1) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx
//   Directed self-checking bench for serial_parity_rx (DATA_W=8). A table
//   of frames with hand-computed results is applied back to back, followed
//   by hand-written reset-abort and (optionally) error-counter sequences.
module tb_serial_parity_rx;
  import serial_parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       rx_bit;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_parity_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int unsigned gap;      // bit_en period in clock cycles
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe: gap-1 idle cycles with bit_en low, then one cycle with
  // bit_en high. Returns #1 after the sampling edge.
  task automatic strobe(input logic b, input int unsigned gap);
    for (int unsigned k = 1; k < gap; k++) begin
      bit_en = 1'b0;
      rx_bit = IDLE_LEVEL;
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
    rx_bit = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    rx_bit = IDLE_LEVEL;
  endtask

  task automatic send_frame(input vec_t v, input logic [7:0] prev_data,
                            input logic prev_perr, input logic prev_ferr);
    int early_valid = 0;
    int busy_hi     = 0;
    strobe(START_BIT, v.gap);
    if (busy) busy_hi++;
    check("valid_low_after_start", data_valid, 0);
    check("hold_data", data_out, prev_data);
    check("hold_perr", parity_err, prev_perr);
    check("hold_ferr", frame_err, prev_ferr);
    for (int i = 0; i < 8; i++) begin
      strobe(v.data[i], v.gap);
      if (busy) busy_hi++;
      if (data_valid) early_valid++;
    end
    strobe(v.par, v.gap);
    if (busy) busy_hi++;
    if (data_valid) early_valid++;
    check("no_early_valid", early_valid, 0);
    strobe(v.stop, v.gap);
    check("valid_pulse", data_valid, 1);
    check("data_out", data_out, v.exp_data);
    check("parity_err", parity_err, v.exp_perr);
    check("frame_err", frame_err, v.exp_ferr);
    check("busy_low_after_stop", busy, 0);
    // busy high after strobes 1..10, falling on strobe 11 -> spans 11 strobes
    check("busy_span", busy_hi + 1, 11);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] pd;
    logic       pp, pf;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 4, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 1, 8'h5A, 1'b1, 1'b1};

    rst    = 1'b1;
    bit_en = 1'b0;
    rx_bit = IDLE_LEVEL;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    check("rst_errcnt", err_cnt, 0);
`endif
    rst = 1'b0;

    // idle line with bit_en high stays idle
    bit_en = 1'b1;
    rx_bit = IDLE_LEVEL;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", data_valid, 0);

    // table frames, back to back
    pd = 8'h00; pp = 1'b0; pf = 1'b0;
    foreach (vecs[i]) begin
      send_frame(vecs[i], pd, pp, pf);
      pd = vecs[i].exp_data;
      pp = vecs[i].exp_perr;
      pf = vecs[i].exp_ferr;
    end

    // valid drops after one cycle even with bit_en held high
    bit_en = 1'b1;
    rx_bit = IDLE_LEVEL;
    @(posedge clk); #1;
    check("valid_one_cycle", data_valid, 0);
    check("held_data", data_out, 8'h5A);
    check("held_perr", parity_err, 1);
    check("held_ferr", frame_err, 1);
    bit_en = 1'b0;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    // errored frames: 01 (parity), FF (frame), 5A (both, counted once)
    check("errcnt_table", err_cnt, 3);
`endif

    // reset in the middle of a frame after the 4th data bit
    begin
      int v_seen = 0;
      logic [7:0] abort_word = 8'h0F;
      strobe(START_BIT, 1);
      for (int i = 0; i < 4; i++) begin
        strobe(abort_word[i], 1);
        if (data_valid) v_seen++;
      end
      check("abort_busy_before_rst", busy, 1);
      rst    = 1'b1;
      bit_en = 1'b1;
      rx_bit = 1'b1;
      @(posedge clk); #1;
      if (data_valid) v_seen++;
      rst    = 1'b0;
      bit_en = 1'b0;
      check("abort_no_valid", v_seen, 0);
      check("abort_data", data_out, 0);
      check("abort_perr", parity_err, 0);
      check("abort_ferr", frame_err, 0);
      check("abort_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
        strobe(IDLE_LEVEL, 1);
        if (data_valid) v_seen++;
      end
      check("abort_stays_idle", busy, 0);
      check("abort_no_late_valid", v_seen, 0);
    end
    begin
      vec_t v5 = '{8'h5A, 1'b1, 1'b1, 1, 8'h5A, 1'b0, 1'b0};
      send_frame(v5, 8'h00, 1'b0, 1'b0);
    end

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    check("errcnt_after_rst", err_cnt, 0);
    begin
      vec_t ve = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 1'b1, 1'b0};
      pd = 8'h5A; pp = 1'b0; pf = 1'b0;
      for (int n = 0; n < 300; n++) begin
        send_frame(ve, pd, pp, pf);
        pd = 8'h01; pp = 1'b1; pf = 1'b0;
        if (n == 9) check("errcnt_10", err_cnt, 10);
      end
      check("errcnt_sat", err_cnt, 8'hFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
